mdu_seq: RTL

- Sequencer and interlock for the CPU multiply/divide unit. Owns the HI/LO registers.
- Drives the combinational multiplier and the iterative divider (start/busy/over handshake).
- Lets the pipeline run while an operation is in flight. Deasserts pc_ena only when a later MDU instruction, or an HI/LO read, arrives while the unit is busy.
- Sits between decode/execute and the MUL/MULTU/DIV1/DIVU1 arithmetic blocks.

---
 rtl/mdu_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: multiply/divide sequencer that owns HI/LO and stalls the pipeline on MDU hazards.
// Optional macro MDU_DIV0_BYPASS_EN resolves divide-by-zero locally instead of using the divider.
module mdu_seq #(
  parameter int unsigned MUL_LAT     = 2,
  parameter int unsigned DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic        rd_req,
  input  logic        rd_sel,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        pc_ena,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic [63:0] mul_z,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_abort,
  input  logic        div_busy,
  input  logic        div_over,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TO_W  = $clog2(DIV_TIMEOUT + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DSTART, DWAIT} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   tcnt;
  logic              op_hit;
  logic              accept;
  logic              div0_bypass;

  assign op_hit  = op_valid && (op != 3'd0) && (op != 3'd7);
  assign busy    = (state != IDLE);
  assign accept  = op_hit && !busy;
  assign pc_ena  = !(busy && (op_hit || rd_req));
  assign rd_data = rd_sel ? hi : lo;

`ifdef MDU_DIV0_BYPASS_EN
  assign div0_bypass = (rt_data == 32'd0);
`else
  assign div0_bypass = 1'b0;
`endif

  // Sequencer: accepts ops in IDLE, runs the multiplier hold or divider handshake, writes HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      tcnt         <= '0;
      hi           <= '0;
      lo           <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_signed   <= 1'b0;
      div_start    <= 1'b0;
      div_signed   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_abort    <= 1'b0;
      err          <= 1'b0;
    end else begin
      div_start <= 1'b0;
      div_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
              OP_MULT, OP_MULTU: begin
                mul_a      <= rs_data;
                mul_b      <= rt_data;
                mul_signed <= (op == OP_MULT);
                cnt        <= CNT_W'(MUL_LAT - 1);
                state      <= MUL;
              end
              OP_DIV, OP_DIVU: begin
                if (div0_bypass) begin
                  hi <= rs_data;
                  lo <= 32'hFFFF_FFFF;
                end else begin
                  div_dividend <= rs_data;
                  div_divisor  <= rt_data;
                  div_signed   <= (op == OP_DIV);
                  state        <= DSTART;
                end
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= mul_z;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DSTART: begin
          // Wait for the divider to be free before issuing the single start pulse.
          if (!div_busy) begin
            div_start <= 1'b1;
            tcnt      <= '0;
            state     <= DWAIT;
          end
        end
        DWAIT: begin
          if (div_over) begin
            lo    <= div_q;
            hi    <= div_r;
            state <= IDLE;
          end else if (tcnt == TO_W'(DIV_TIMEOUT - 1)) begin
            div_abort <= 1'b1;
            err       <= 1'b1;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
